lcd_text_refresh: RTL and testbench

Parametrised character-LCD text engine for HD44780-class panels. It holds a ROWS×COLS character buffer that the host writes at any time. After a one-time init sequence, it redraws the whole panel continuously, so buffer updates appear without a reset. It sits between the datapath/debug logic and the existing byte-level LCD controller, which it drives through a start/done handshake.

---
 rtl/lcd_text_refresh.sv | 213 +++++++++++++++++++++
 tb/tb_lcd_text_refresh.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh: character-LCD text engine for HD44780-class panels.
// Holds a ROWS x COLS character buffer and, after a one-time init sequence,
// redraws the whole panel continuously through a start/done byte handshake
// with the downstream byte-level LCD controller.
// Optional feature: define LCD_TEXT_HEX_EN to add the hex_en/hex_value port
// pair, which expands a 32-bit value into 8 hex digit characters.
module lcd_text_refresh #(
  parameter int COLS       = 16,
  parameter int ROWS       = 2,
  parameter int DLY_CYCLES = 262142,
  parameter int AW         = $clog2(ROWS * COLS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_ready,
`ifdef LCD_TEXT_HEX_EN
  input  logic          hex_en,
  input  logic [31:0]   hex_value,
`endif
  output logic [7:0]    lcd_data,
  output logic          lcd_rs,
  output logic          lcd_start,
  input  logic          lcd_done,
  output logic          init_done,
  output logic          frame_done
);

  localparam int CELLS = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(COLS + 1);
  localparam int DW    = $clog2(DLY_CYCLES + 2);

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_DELAY   = 2'd2;
  localparam logic [1:0] ST_ADVANCE = 2'd3;

  logic [7:0]    buffer [CELLS];
  logic          cell_we;
  logic [AW-1:0] cell_waddr;
  logic [7:0]    cell_wdata;

  logic [1:0]    state;
  logic          sending_init;
  logic [1:0]    init_idx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [DW-1:0] dly_cnt;
  logic [7:0]    load_data;
  logic          load_rs;
  logic [AW-1:0] rd_idx;
  logic          last_row;
  logic          last_col;

  // DDRAM address of the first character of a row.
  function automatic logic [7:0] row_base(input logic [RW-1:0] r);
    if (int'(r) == 1)      return 8'h40;
    else if (int'(r) == 2) return 8'h14;
    else if (int'(r) == 3) return 8'h54;
    else                   return 8'h00;
  endfunction

`ifdef LCD_TEXT_HEX_EN
  // One extra nibble of headroom so addr+7 never wraps inside the counter.
  logic [3:0]    hex_cnt;
  logic [AW+3:0] hex_addr;
  logic [31:0]   hex_shift;

  function automatic logic [7:0] hex_digit(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign wr_ready = (hex_cnt == 4'd0);

  // Latch a hex request and walk its nibbles out, most significant first.
  always_ff @(posedge clock) begin
    if (reset) begin
      hex_cnt   <= 4'd0;
      hex_addr  <= '0;
      hex_shift <= 32'h0;
    end else if (hex_en && wr_ready) begin
      hex_cnt   <= 4'd8;
      hex_addr  <= (AW+4)'(wr_addr);
      hex_shift <= hex_value;
    end else if (hex_cnt != 4'd0) begin
      hex_cnt   <= hex_cnt - 4'd1;
      hex_addr  <= hex_addr + 1'b1;
      hex_shift <= {hex_shift[27:0], 4'h0};
    end
  end

  // Pick the buffer write source: hex expansion owns the port while busy,
  // and a hex request in the same cycle as wr_en wins.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    cell_we    = 1'b0;
    cell_waddr = wr_addr;
    cell_wdata = wr_data;
    if (hex_cnt != 4'd0) begin
      cell_we    = (int'(hex_addr) < CELLS);
      cell_waddr = hex_addr[AW-1:0];
      cell_wdata = hex_digit(hex_shift[31:28]);
    end else if (wr_en && !hex_en) begin
      cell_we    = (int'(wr_addr) < CELLS);
    end
  end
`else
  assign wr_ready = 1'b1;

  // Host writes go straight to the buffer; out-of-range addresses are dropped.
  always_comb begin
    cell_we    = wr_en && (int'(wr_addr) < CELLS);
    cell_waddr = wr_addr;
    cell_wdata = wr_data;
  end
`endif

  // Character buffer; every cell resets to a space.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: this buffer is plain flops, so it can be reset cell by cell;
      // a RAM-inferred array would have to be cleared by a write sweep instead.
      for (int i = 0; i < CELLS; i++) buffer[i] <= 8'h20;
    end else if (cell_we) begin
      buffer[cell_waddr] <= cell_wdata;
    end
  end

  assign last_row = (row == RW'(ROWS - 1));
  assign last_col = (col == CW'(COLS));
  assign rd_idx   = AW'(int'(row) * COLS + int'(col) - 1);

  // Byte the sequencer would send from its current list position.
  always_comb begin
    load_data = 8'h00;
    load_rs   = 1'b0;
    if (sending_init) begin
      case (init_idx)
        2'd0:    load_data = 8'h38;
        2'd1:    load_data = 8'h0C;
        2'd2:    load_data = 8'h01;
        default: load_data = 8'h06;
      endcase
    end else if (col == '0) begin
      load_data = 8'h80 | row_base(row);
    end else begin
      load_data = buffer[rd_idx];
      load_rs   = 1'b1;
    end
  end

  // Per-byte handshake FSM and byte-list position.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_LOAD;
      lcd_data     <= 8'h00;
      lcd_rs       <= 1'b0;
      lcd_start    <= 1'b0;
      init_done    <= 1'b0;
      frame_done   <= 1'b0;
      sending_init <= 1'b1;
      init_idx     <= 2'd0;
      row          <= '0;
      col          <= '0;
      dly_cnt      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      frame_done <= 1'b0;
      case (state)
        ST_LOAD: begin
          lcd_data  <= load_data;
          lcd_rs    <= load_rs;
          lcd_start <= 1'b1;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lcd_done) begin
            lcd_start <= 1'b0;
            dly_cnt   <= '0;
            state     <= ST_DELAY;
          end
        end
        ST_DELAY: begin
          if (dly_cnt == DW'(DLY_CYCLES)) begin
            state <= ST_ADVANCE;
            // Status flags are raised so they are high during ADVANCE.
            if (sending_init && init_idx == 2'd3) init_done <= 1'b1;
            if (!sending_init && last_row && last_col) frame_done <= 1'b1;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_LOAD;
          if (sending_init) begin
            if (init_idx == 2'd3) sending_init <= 1'b0;
            else                  init_idx     <= init_idx + 2'd1;
          end else if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_refresh.sv
// tb_lcd_text_refresh: self-checking bench for lcd_text_refresh.
// Unit 0 is a 2x16 panel, unit 1 a 4x20 panel, both with a short settle delay.
// A controller model answers each lcd_start with lcd_done three cycles later
// and logs every byte (and frame_done pulses) into a per-unit queue, which the
// test tasks compare with a frame built from a character-array reference.
// Define LCD_TEXT_HEX_EN to build and exercise the hex expansion feature.
module tb_lcd_text_refresh;

  localparam int MARK = 32'h1000;

  logic        clock;
  logic [1:0]  reset_v;
  logic [1:0]  wr_en_v;
  logic [4:0]  wr_addr0;
  logic [6:0]  wr_addr1;
  logic [7:0]  wr_data;
  logic [1:0]  ready_v;
  logic [1:0]  hex_en_v;
  logic [31:0] hex_value;
  logic [7:0]  data_v [2];
  logic [1:0]  rs_v;
  logic [1:0]  start_v;
  logic [1:0]  done_v;
  logic [1:0]  init_v;
  logic [1:0]  frame_v;

  int q [2][$];
  int mbuf [2][80];
  int n_checks = 0;
  int n_fail = 0;

  lcd_text_refresh #(.COLS(16), .ROWS(2), .DLY_CYCLES(4)) u_dut0 (
    .clock(clock), .reset(reset_v[0]),
    .wr_en(wr_en_v[0]), .wr_addr(wr_addr0), .wr_data(wr_data), .wr_ready(ready_v[0]),
`ifdef LCD_TEXT_HEX_EN
    .hex_en(hex_en_v[0]), .hex_value(hex_value),
`endif
    .lcd_data(data_v[0]), .lcd_rs(rs_v[0]), .lcd_start(start_v[0]), .lcd_done(done_v[0]),
    .init_done(init_v[0]), .frame_done(frame_v[0])
  );

  lcd_text_refresh #(.COLS(20), .ROWS(4), .DLY_CYCLES(4)) u_dut1 (
    .clock(clock), .reset(reset_v[1]),
    .wr_en(wr_en_v[1]), .wr_addr(wr_addr1), .wr_data(wr_data), .wr_ready(ready_v[1]),
`ifdef LCD_TEXT_HEX_EN
    .hex_en(hex_en_v[1]), .hex_value(hex_value),
`endif
    .lcd_data(data_v[1]), .lcd_rs(rs_v[1]), .lcd_start(start_v[1]), .lcd_done(done_v[1]),
    .init_done(init_v[1]), .frame_done(frame_v[1])
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Byte-level controller model and byte logger for both units.
  initial begin
    int cnt [2];
    logic [1:0] prev;
    done_v = 2'b00;
    prev   = 2'b00;
    cnt[0] = 0;
    cnt[1] = 0;
    forever begin
      @(posedge clock);
      #1;
      for (int u = 0; u < 2; u++) begin
        done_v[u] = 1'b0;
        if (reset_v[u]) begin
          prev[u] = 1'b0;
          cnt[u]  = 0;
        end else begin
          if (frame_v[u]) q[u].push_back(MARK);
          if (cnt[u] > 0) begin
            cnt[u]--;
            if (cnt[u] == 0) done_v[u] = 1'b1;
          end
          if (start_v[u] && !prev[u]) begin
            q[u].push_back(int'({init_v[u], rs_v[u], data_v[u]}));
            cnt[u] = 3;
          end
          prev[u] = start_v[u];
        end
      end
    end
  end

  function automatic int cols_of(input int u);
    return (u == 0) ? 16 : 20;
  endfunction

  function automatic int rows_of(input int u);
    return (u == 0) ? 2 : 4;
  endfunction

  function automatic int base_of(input int r);
    int bases [4] = '{8'h00, 8'h40, 8'h14, 8'h54};
    return bases[r];
  endfunction

  task automatic clear_model(input int u);
    for (int i = 0; i < 80; i++) mbuf[u][i] = 8'h20;
  endtask

  task automatic get_event(input int u, output int ev);
    int budget = 2000;
    while (q[u].size() == 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (q[u].size() == 0) begin
      ev = -1;
      n_checks++;
      n_fail++;
      $display("FAIL timeout unit%0d: no controller byte seen, required one within 2000 cycles", u);
    end else begin
      ev = q[u].pop_front();
    end
  endtask

  task automatic expect_byte(input int u, input string tag, input int init, input int rs, input int data);
    int ev;
    int exp;
    exp = (init << 9) | (rs << 8) | data;
    get_event(u, ev);
    n_checks++;
    if (ev !== exp) begin
      n_fail++;
      $display("FAIL %s unit%0d byte: got init/rs/data=%03h, required %03h", tag, u, ev, exp);
    end
  endtask

  task automatic expect_marker(input int u, input string tag);
    int ev;
    get_event(u, ev);
    n_checks++;
    if (ev !== MARK) begin
      n_fail++;
      $display("FAIL %s unit%0d frame_done: got event %0h, required frame_done pulse", tag, u, ev);
    end
  endtask

  task automatic expect_cell(input int u, input string tag, input int r, input int c);
    expect_byte(u, tag, 1, 1, mbuf[u][r * cols_of(u) + c]);
  endtask

  task automatic expect_init(input int u, input string tag);
    int seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    for (int i = 0; i < 4; i++) expect_byte(u, tag, 0, 0, seq[i]);
  endtask

  task automatic expect_frame(input int u, input string tag);
    for (int r = 0; r < rows_of(u); r++) begin
      expect_byte(u, tag, 1, 0, 8'h80 | base_of(r));
      for (int c = 0; c < cols_of(u); c++) expect_cell(u, tag, r, c);
    end
    expect_marker(u, tag);
  endtask

  task automatic write_cell(input int u, input int addr, input int data);
    wr_en_v[u] = 1'b1;
    wr_addr0   = 5'(addr);
    wr_addr1   = 7'(addr);
    wr_data    = 8'(data);
    @(negedge clock);
    wr_en_v[u] = 1'b0;
    if (addr < rows_of(u) * cols_of(u)) mbuf[u][addr] = data;
  endtask

  task automatic test_reset();
    reset_v = 2'b11;
    repeat (3) @(negedge clock);
    n_checks++;
    if (start_v[0] !== 1'b0 || data_v[0] !== 8'h00 || rs_v[0] !== 1'b0 ||
        init_v[0] !== 1'b0 || frame_v[0] !== 1'b0 || ready_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: got start=%b data=%02h rs=%b init=%b frame=%b ready=%b, required 0 00 0 0 0 1",
               start_v[0], data_v[0], rs_v[0], init_v[0], frame_v[0], ready_v[0]);
    end
    q[0].delete();
    clear_model(0);
    reset_v[0] = 1'b0;
  endtask

  task automatic test_init_and_frame();
    expect_init(0, "init_seq");
    expect_frame(0, "idle_frame");
    expect_frame(0, "loop_frame");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++)
        write_cell(0, $urandom_range(0, 31), $urandom_range(8'h21, 8'h7E));
      expect_frame(0, "random_frame");
    end
  endtask

  task automatic test_midframe_write();
    expect_byte(0, "mid_row0_cmd", 1, 0, 8'h80);
    for (int c = 0; c < 3; c++) expect_cell(0, "mid_row0", 0, c);
    write_cell(0, 17, 8'h41);
    for (int c = 3; c < 16; c++) expect_cell(0, "mid_row0", 0, c);
    expect_byte(0, "mid_row1_cmd", 1, 0, 8'hC0);
    expect_byte(0, "mid_row1_col0", 1, 1, mbuf[0][16]);
    expect_byte(0, "mid_same_frame_0x41", 1, 1, 8'h41);
    for (int c = 2; c < 16; c++) expect_cell(0, "mid_row1", 1, c);
    write_cell(0, 17, 8'h42);
    expect_marker(0, "mid_end");
    expect_frame(0, "late_write_next_frame");
  endtask

`ifdef LCD_TEXT_HEX_EN
  task automatic hex_model(input int u, input int addr, input logic [31:0] val);
    string s;
    s = $sformatf("%08X", val);
    for (int i = 0; i < 8; i++)
      if (addr + i < rows_of(u) * cols_of(u)) mbuf[u][addr + i] = int'(s[i]);
  endtask

  task automatic test_hex();
    hex_en_v[0] = 1'b1;
    hex_value   = 32'hDEADBEEF;
    wr_en_v[0]  = 1'b1;
    wr_addr0    = 5'd4;
    wr_data     = 8'h5B;
    @(negedge clock);
    hex_en_v[0] = 1'b0;
    wr_en_v[0]  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_checks++;
      if (ready_v[0] !== (i == 8)) begin
        n_fail++;
        $display("FAIL hex_wr_ready cycle %0d: got %b, required %b", i, ready_v[0], (i == 8));
      end
      if (i == 2) begin
        wr_en_v[0] = 1'b1;
        wr_addr0   = 5'd0;
        wr_data    = 8'h5A;
      end else begin
        wr_en_v[0] = 1'b0;
      end
      @(negedge clock);
    end
    hex_model(0, 4, 32'hDEADBEEF);
    expect_frame(0, "hex_deadbeef");
    hex_en_v[0] = 1'b1;
    wr_addr0    = 5'd28;
    @(negedge clock);
    hex_en_v[0] = 1'b0;
    repeat (8) @(negedge clock);
    hex_model(0, 28, 32'hDEADBEEF);
    expect_frame(0, "hex_clipped");
  endtask
`endif

  task automatic test_reset_in_wait();
    int budget = 200;
    while (start_v[0] !== 1'b1 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    n_checks++;
    if (start_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_for_start: got lcd_start=%b, required 1 within 200 cycles", start_v[0]);
    end
    reset_v[0] = 1'b1;
    @(negedge clock);
    n_checks++;
    if (start_v[0] !== 1'b0 || init_v[0] !== 1'b0 || data_v[0] !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_in_wait: got start=%b init=%b data=%02h, required 0 0 00",
               start_v[0], init_v[0], data_v[0]);
    end
    @(negedge clock);
    q[0].delete();
    clear_model(0);
    reset_v[0] = 1'b0;
    expect_init(0, "reinit");
    expect_frame(0, "post_reset_blank");
  endtask

  task automatic test_big_panel();
    q[1].delete();
    clear_model(1);
    reset_v[1] = 1'b0;
    expect_init(1, "big_init");
    expect_frame(1, "big_blank");
    for (int i = 0; i < 4; i++)
      write_cell(1, $urandom_range(0, 79), $urandom_range(8'h21, 8'h7E));
    for (int i = 0; i < 3; i++)
      write_cell(1, $urandom_range(80, 127), $urandom_range(8'h21, 8'h7E));
    expect_frame(1, "big_random_oob");
  endtask

  initial begin
    reset_v   = 2'b11;
    wr_en_v   = 2'b00;
    hex_en_v  = 2'b00;
    wr_addr0  = '0;
    wr_addr1  = '0;
    wr_data   = 8'h00;
    hex_value = 32'h0;
    test_reset();
    test_init_and_frame();
    test_random_frames();
    test_midframe_write();
`ifdef LCD_TEXT_HEX_EN
    test_hex();
`endif
    test_reset_in_wait();
    test_big_panel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
